// File: rtl/mux_b2_arb_pkg.sv
// Shared types and constants for the two-requester inverting-mux arbiter.
// Used by mux_b2_arbiter; the optional output register is selected with
// the macro MUX_B2_ARB_OUT_REG_EN in the top file.
package mux_b2_arb_pkg;

  // Arbiter states: no owner, requester 0 owns the mux, requester 1 owns it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_t;

  // Value the last-granted pointer takes on reset, so requester 0 wins the
  // first tie after reset.
  localparam logic LAST_RST = 1'b1;

  // Legal span of MAX_HOLD.
  localparam int MAX_HOLD_MIN = 1;
  localparam int MAX_HOLD_MAX = 255;

  // True when the hold limit fits the legal span and the counter is wide
  // enough to reach MAX_HOLD-1 without wrapping.
  function automatic bit max_hold_legal(input int max_hold, input int cnt_w);
    return (max_hold >= MAX_HOLD_MIN) && (max_hold <= MAX_HOLD_MAX) &&
           (cnt_w >= 1) && (cnt_w < 31) && ((1 << cnt_w) > max_hold);
  endfunction

endpackage

// File: rtl/mux_b2_inv_bank.sv
// WIDTH-bit inverting 2:1 mux bank: Z = ~(SL ? A1 : A0). Purely combinational.
module mux_b2_inv_bank #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic             SL,
  output logic [WIDTH-1:0] Z
);

  // Select one leg and invert it, as the std-cell mux bank does.
  always_comb begin
    Z = SL ? ~A1 : ~A0;
  end

endmodule

// File: rtl/mux_b2_arbiter.sv
// Two-requester round-robin arbiter owning the select of a shared inverting
// 2:1 mux bank. Grants are registered, contended ownership is bounded by
// MAX_HOLD unless LOCK is held, and handover between requesters has no bubble.
// Optional macro MUX_B2_ARB_OUT_REG_EN registers Z and VALID (one extra cycle).
module mux_b2_arbiter
  import mux_b2_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic             LOCK,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             SL,
  output logic [WIDTH-1:0] Z,
  output logic             VALID
);

  // Reject an unreachable or over-range hold limit at elaboration.
  if (!max_hold_legal(MAX_HOLD, CNT_W)) begin : g_bad_cfg
    $error("mux_b2_arbiter: MAX_HOLD must be 1..255 and below 2**CNT_W");
  end

  // Count value at which a contended, unlocked owner must hand over.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt1_q;
  logic             other_req;
  logic [WIDTH-1:0] z_mux;

  // Next state, hold counter and last-granted pointer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    other_req = 1'b0;

    case (state_q)
      IDLE: begin
        // LOCK has no meaning without an owner.
        if (REQ0 && REQ1) begin
          state_d = last_q ? G0 : G1;
        end else if (REQ0) begin
          state_d = G0;
        end else if (REQ1) begin
          state_d = G1;
        end
      end
      G0: begin
        other_req = REQ1;
        if (!REQ0) begin
          // Releasing always wins over LOCK; hand straight over if wanted.
          state_d = REQ1 ? G1 : IDLE;
        end else if (REQ1 && !LOCK && (cnt_q == HOLD_LAST)) begin
          state_d = G1;
        end
      end
      G1: begin
        other_req = REQ0;
        if (!REQ1) begin
          state_d = REQ0 ? G0 : IDLE;
        end else if (REQ0 && !LOCK && (cnt_q == HOLD_LAST)) begin
          state_d = G0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == G0) last_d = 1'b0;
      if (state_d == G1) last_d = 1'b1;
    end else if ((state_q != IDLE) && other_req && !LOCK) begin
      // Only unlocked, contended cycles count toward the hold limit, so a
      // released LOCK gives the owner a fresh MAX_HOLD window.
      cnt_d = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Arbiter FSM state with registered grant outputs.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt0_q  <= (state_d == G0);
      gnt1_q  <= (state_d == G1);
    end
  end

  assign GNT0 = gnt0_q;
  assign GNT1 = gnt1_q;
  assign SL   = gnt1_q;

  mux_b2_inv_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .A0 (D0),
    .A1 (D1),
    .SL (gnt1_q),
    .Z  (z_mux)
  );

`ifdef MUX_B2_ARB_OUT_REG_EN
  logic [WIDTH-1:0] z_q;
  logic             valid_q;

  // Output register: Z and VALID trail the select by one cycle.
  always_ff @(posedge CK) begin
    if (RST) begin
      z_q     <= '1;
      valid_q <= 1'b0;
    end else begin
      z_q     <= z_mux;
      valid_q <= gnt0_q | gnt1_q;
    end
  end

  assign Z     = z_q;
  assign VALID = valid_q;
`else
  assign Z     = z_mux;
  assign VALID = gnt0_q | gnt1_q;
`endif

endmodule

// File: tb/tb_mux_b2_arbiter.sv
// Self-checking bench for mux_b2_arbiter (default MAX_HOLD=4) plus a
// MAX_HOLD=1 instance for the every-cycle alternation corner.
module tb_mux_b2_arbiter;

  logic       CK = 1'b0;
  logic       RST, REQ0, REQ1, LOCK;
  logic [7:0] D0, D1;
  logic       GNT0, GNT1, SL, VALID;
  logic [7:0] Z;
  logic       GNT0_1, GNT1_1, SL_1, VALID_1;
  logic [7:0] Z_1;

  always #5 CK = ~CK;

  mux_b2_arbiter #(.WIDTH(8), .MAX_HOLD(4), .CNT_W(8)) u_dut (
    .CK(CK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .LOCK(LOCK),
    .D0(D0), .D1(D1), .GNT0(GNT0), .GNT1(GNT1), .SL(SL), .Z(Z), .VALID(VALID)
  );

  mux_b2_arbiter #(.WIDTH(8), .MAX_HOLD(1), .CNT_W(8)) u_dut1 (
    .CK(CK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .LOCK(LOCK),
    .D0(D0), .D1(D1), .GNT0(GNT0_1), .GNT1(GNT1_1), .SL(SL_1), .Z(Z_1),
    .VALID(VALID_1)
  );

  typedef struct {
    logic       rst, r0, r1, lk;
    logic [7:0] d0, d1;
    logic       g0, g1;   // expected grants after the edge
  } vec_t;

  typedef struct {
    int         idx;
    logic       g0, g1, valid;
    logic [7:0] z;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic add(input logic rst, input logic r0, input logic r1, input logic lk,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic g0, input logic g1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.lk = lk;
    v.d0 = d0; v.d1 = d1; v.g0 = g0; v.g1 = g1;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t       e, got;
    logic       prev_sl, prev_valid;
    int         lat;

    RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; LOCK = 1'b0; D0 = '0; D1 = '0;
    prev_sl = 1'b0; prev_valid = 1'b0;

    //    rst r0 r1 lk  d0     d1     g0 g1
    add(1, 0, 0, 0, 8'h0F, 8'h00, 0, 0);  // reset state
    add(0, 1, 0, 0, 8'hA5, 8'h00, 1, 0);  // single REQ0, 1-cycle latency
    add(0, 0, 0, 0, 8'hA5, 8'h00, 0, 0);  // release -> IDLE
    add(1, 0, 0, 0, 8'h0F, 8'h00, 0, 0);
    add(0, 1, 1, 0, 8'h11, 8'h3C, 1, 0);  // tie after reset -> G0
    add(0, 1, 1, 0, 8'h22, 8'h3C, 1, 0);
    add(0, 1, 1, 0, 8'h33, 8'h3C, 1, 0);
    add(0, 1, 1, 0, 8'h44, 8'h3C, 1, 0);
    add(0, 1, 1, 0, 8'h55, 8'h3C, 0, 1);  // forced rotation after 4
    add(0, 1, 1, 0, 8'h55, 8'h3C, 0, 1);
    add(0, 1, 1, 0, 8'h55, 8'h96, 0, 1);
    add(0, 1, 1, 0, 8'h55, 8'h69, 0, 1);
    add(0, 1, 1, 0, 8'hC7, 8'h69, 1, 0);  // back to G0
    for (int i = 0; i < 10; i++)          // LOCK holds G0 for 10 cycles
      add(0, 1, 1, 1, 8'(i * 17), 8'hE1, 1, 0);
    add(0, 1, 1, 0, 8'h01, 8'h02, 1, 0);  // count restarts at 0
    add(0, 1, 1, 0, 8'h01, 8'h02, 1, 0);
    add(0, 1, 1, 0, 8'h01, 8'h02, 1, 0);
    add(0, 1, 1, 0, 8'h01, 8'h02, 0, 1);
    add(0, 1, 0, 0, 8'h7E, 8'h81, 1, 0);  // REQ1 drops, REQ0 waiting
    add(0, 0, 1, 0, 8'h7E, 8'h81, 0, 1);  // REQ0 drops as REQ1 rises
    add(0, 0, 1, 0, 8'hFF, 8'h00, 0, 1);
    add(0, 0, 0, 0, 8'hFF, 8'h00, 0, 0);
    add(0, 1, 1, 0, 8'h5A, 8'hA5, 1, 0);  // last was 1 -> G0
    add(0, 1, 1, 0, 8'h5A, 8'hA5, 1, 0);
    add(0, 0, 1, 0, 8'h5A, 8'hA5, 0, 1);
    add(1, 0, 1, 0, 8'h0F, 8'hA5, 0, 0);  // reset mid-grant in G1
    add(0, 1, 1, 0, 8'h0F, 8'hA5, 1, 0);  // pointer restored by reset
    add(0, 0, 0, 0, 8'h0F, 8'hA5, 0, 0);
    add(0, 0, 1, 1, 8'h0F, 8'hB4, 0, 1);  // LOCK ignored in IDLE
    add(0, 0, 1, 1, 8'h0F, 8'hB4, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CK);
      RST = vecs[i].rst; REQ0 = vecs[i].r0; REQ1 = vecs[i].r1; LOCK = vecs[i].lk;
      D0 = vecs[i].d0; D1 = vecs[i].d1;
      e.idx = i; e.g0 = vecs[i].g0; e.g1 = vecs[i].g1;
`ifdef MUX_B2_ARB_OUT_REG_EN
      if (vecs[i].rst) begin
        e.z = 8'hFF; e.valid = 1'b0;
      end else begin
        e.z = prev_sl ? ~vecs[i].d1 : ~vecs[i].d0;
        e.valid = prev_valid;
      end
`else
      e.z = vecs[i].g1 ? ~vecs[i].d1 : ~vecs[i].d0;
      e.valid = vecs[i].g0 | vecs[i].g1;
`endif
      prev_sl = vecs[i].g1; prev_valid = vecs[i].g0 | vecs[i].g1;
      sb.push_back(e);
      @(posedge CK); #1;
      got = sb.pop_front();
      check("gnt0",  got.idx, 32'(GNT0),  32'(got.g0));
      check("gnt1",  got.idx, 32'(GNT1),  32'(got.g1));
      check("sl",    got.idx, 32'(SL),    32'(got.g1));
      check("z",     got.idx, 32'(Z),     32'(got.z));
      check("valid", got.idx, 32'(VALID), 32'(got.valid));
    end

    // Grant latency from IDLE, bounded wait.
    @(negedge CK); RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; LOCK = 1'b0;
    @(negedge CK); RST = 1'b0; REQ1 = 1'b1;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge CK); #1;
      if (GNT1 === 1'b1) begin lat = c; break; end
    end
    check("latency", 0, 32'(lat), 32'd1);

    // MAX_HOLD=1 with both requesting: grants alternate every cycle.
    @(negedge CK); RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CK); RST = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge CK); #1;
      check("alt_gnt0", k, 32'(GNT0_1), 32'(k % 2 == 0));
      check("alt_gnt1", k, 32'(GNT1_1), 32'(k % 2 == 1));
    end

    @(negedge CK); REQ0 = 1'b0; REQ1 = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
